// File: rtl/pump_dose_timer.sv
// rtl/pump_dose_timer.sv - per-pump dose timer issuing stop requests, completion pulses and stuck-pump faults
module pump_dose_timer #(
    parameter int DOSE_CYCLES  = 50000000,
    parameter int CNT_W        = 26,
    parameter int STOP_MIN     = 4,
    parameter int STOP_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic       pump1,
    input  logic       pump2,
    input  logic       pump3,
    input  logic       pump4,
    output logic       out_ctrl0,
    output logic       out_ctrl1,
    output logic       out_ctrl2,
    output logic       out_ctrl3,
    output logic [3:0] pour_done,
    output logic [3:0] pour_abort,
    output logic [7:0] pour_count,
    output logic       busy,
    output logic [3:0] fault
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_POUR  = 2'd1;
    localparam logic [1:0] ST_STOP  = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;
    localparam int SW = (STOP_TIMEOUT > 2) ? $clog2(STOP_TIMEOUT) : 1;

    logic [3:0] pump_meta_q, pump_s_q;
    logic [3:0] done_d, abort_d, out_ctrl_d, fault_d, active_d;
    logic [3:0] out_ctrl_q, pour_done_q, pour_abort_q, fault_q;
    logic [7:0] pour_count_q, pour_count_d;
    logic       busy_q;

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            pump_meta_q <= '0;
            pump_s_q    <= '0;
        end else begin
            pump_meta_q <= {pump4, pump3, pump2, pump1};
            pump_s_q    <= pump_meta_q;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_ch
        logic [1:0]       state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [SW-1:0]    stop_cnt_q, stop_cnt_d;
        logic             done, abort;

        // Abort is tested before terminal count so a pump falling in the last dose cycle aborts.
        always_comb begin
            state_d    = state_q;
            cnt_d      = cnt_q;
            stop_cnt_d = stop_cnt_q;
            done       = 1'b0;
            abort      = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pump_s_q[i]) begin
                        state_d = ST_POUR;
                        cnt_d   = '0;
                    end
                end
                ST_POUR: begin
                    cnt_d = cnt_q + 1'b1;
                    if (!pump_s_q[i]) begin
                        state_d = ST_IDLE;
                        abort   = 1'b1;
                    end else if (cnt_q == CNT_W'(DOSE_CYCLES - 1)) begin
                        state_d    = ST_STOP;
                        stop_cnt_d = '0;
                    end
                end
                ST_STOP: begin
                    stop_cnt_d = stop_cnt_q + 1'b1;
                    if (!pump_s_q[i] && (stop_cnt_q >= SW'(STOP_MIN - 1))) begin
                        state_d = ST_IDLE;
                        done    = 1'b1;
                    end else if (pump_s_q[i] && (stop_cnt_q == SW'(STOP_TIMEOUT - 1))) begin
                        state_d = ST_FAULT;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        always_ff @(posedge clk or negedge RESET) begin
            if (!RESET) begin
                state_q    <= ST_IDLE;
                cnt_q      <= '0;
                stop_cnt_q <= '0;
            end else begin
                state_q    <= state_d;
                cnt_q      <= cnt_d;
                stop_cnt_q <= stop_cnt_d;
            end
        end

        assign done_d[i]     = done;
        assign abort_d[i]    = abort;
        assign out_ctrl_d[i] = (state_d == ST_STOP) || (state_d == ST_FAULT);
        assign fault_d[i]    = (state_d == ST_FAULT);
        assign active_d[i]   = (state_d != ST_IDLE);
    end

    // Shared adder: several channels may finish in the same cycle.
    always_comb begin
        pour_count_d = pour_count_q;
        for (int i = 0; i < 4; i++) begin
            pour_count_d = pour_count_d + {7'd0, done_d[i]};
        end
    end

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            out_ctrl_q   <= '0;
            pour_done_q  <= '0;
            pour_abort_q <= '0;
            fault_q      <= '0;
            pour_count_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            out_ctrl_q   <= out_ctrl_d;
            pour_done_q  <= done_d;
            pour_abort_q <= abort_d;
            fault_q      <= fault_d;
            pour_count_q <= pour_count_d;
            busy_q       <= |active_d;
        end
    end

    assign out_ctrl0  = out_ctrl_q[0];
    assign out_ctrl1  = out_ctrl_q[1];
    assign out_ctrl2  = out_ctrl_q[2];
    assign out_ctrl3  = out_ctrl_q[3];
    assign pour_done  = pour_done_q;
    assign pour_abort = pour_abort_q;
    assign pour_count = pour_count_q;
    assign busy       = busy_q;
    assign fault      = fault_q;
endmodule
